// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter; the state encoding and
// load/store opcodes are also used by the pipeline control unit.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        TURN   = 2'd3
    } arb_state_e;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    // Wide enough for any TIMEOUT in 1..255.
    localparam int TO_CNT_W = 8;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access timeout counter: cleared on grant, counts stalled memory cycles and
// flags the cycle on which the TIMEOUT-th stalled cycle is reached.
module arb_timeout_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [TO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count means "this stalled cycle is the last one allowed".
    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (MEM) with
// alternating priority, timeout abort and a pipeline-advance enable.
// Optional wait-cycle counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    input  logic          IKill,
    output logic [31:0]   IRdata,
    output logic          IAck,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [31:0]   DWdata,
    output logic [31:0]   DRdata,
    output logic          DAck,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [31:0]   MemWdata,
    input  logic [31:0]   MemRdata,
    input  logic          MemReady,
    output logic          PipeEn,
    output logic          Err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   IWaitCnt,
    output logic [31:0]   DWaitCnt
`endif
);

    arb_state_e    state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          kill_q, kill_d;
    logic          err_q, err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   irdata_q, irdata_d;
    logic [31:0]   drdata_q, drdata_d;
    logic          busy, kill_now, cnt_clr, cnt_inc, cnt_tc;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i (Clk),
        .rst_i (Rst),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign kill_now = kill_q || ((state_q == BUSY_I) && IKill);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        kill_d      = kill_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the port not served last time wins.
                if (DReq && (!IReq || !last_d_q)) begin
                    state_d     = BUSY_D;
                    mem_addr_d  = DAddr;
                    mem_we_d    = DWe;
                    mem_wdata_d = DWdata;
                    last_d_d    = 1'b1;
                    cnt_clr     = 1'b1;
                end else if (IReq) begin
                    state_d     = BUSY_I;
                    mem_addr_d  = IAddr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    last_d_d    = 1'b0;
                    kill_d      = IKill;
                    cnt_clr     = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                kill_d = kill_now;
                if (MemReady || cnt_tc) begin
                    state_d = TURN;
                    if (!MemReady) begin
                        err_d = 1'b1;
                    end
                    if ((state_q == BUSY_I) && !kill_now) begin
                        irdata_d = MemReady ? MemRdata : 32'h0;
                    end
                    if ((state_q == BUSY_D) && !mem_we_q) begin
                        drdata_d = MemReady ? MemRdata : 32'h0;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            TURN: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            kill_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            kill_q      <= kill_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    // Strobe is decoded from state so it falls as soon as reset asserts.
    assign MemEn    = busy;
    assign MemWe    = busy && mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign IRdata   = irdata_q;
    assign DRdata   = drdata_q;
    assign IAck     = (state_q == TURN) && !last_d_q && !kill_q;
    assign DAck     = (state_q == TURN) && last_d_q;
    assign Err      = err_q;
    assign PipeEn   = !((IReq && !IAck && !IKill) || (DReq && !DAck));

`ifdef ARB_PERF_CNT_EN
    logic [31:0] iwait_q, dwait_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            iwait_q <= '0;
            dwait_q <= '0;
        end else begin
            if (IReq && !IAck && (iwait_q != 32'hFFFF_FFFF)) begin
                iwait_q <= iwait_q + 32'd1;
            end
            if (DReq && !DAck && (dwait_q != 32'hFFFF_FFFF)) begin
                dwait_q <= dwait_q + 32'd1;
            end
        end
    end

    assign IWaitCnt = iwait_q;
    assign DWaitCnt = dwait_q;
`endif

endmodule
